// File: rtl/mult_pkg.sv
// Shared encodings for the sequential multiplier host and its controller:
// controller state codes, host FSM states and the default done timeout.
package mult_pkg;

  typedef enum logic [2:0] {
    C_IDLE      = 3'd0,
    C_LSB       = 3'd1,
    C_MID       = 3'd2,
    C_MSB       = 3'd3,
    C_CALC_DONE = 3'd4,
    C_ERR       = 3'd5
  } ctrl_state_t;

  typedef enum logic [2:0] {
    H_IDLE  = 3'd0,
    H_START = 3'd1,
    H_RUN   = 3'd2,
    H_WAIT  = 3'd3,
    H_RESP  = 3'd4
  } host_state_t;

  localparam int DEFAULT_TIMEOUT_CYCLES = 8;

endpackage

// File: rtl/mult_host_timer.sv
// Counts cycles spent waiting for the controller's done flag.
// Compiled only when MULT_HOST_ERR_CHECK_EN is defined.
`ifdef MULT_HOST_ERR_CHECK_EN
module mult_host_timer #(
  parameter int TIMEOUT_CYCLES = 8
) (
  input  logic clk,
  input  logic reset_a,
  input  logic run_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (run_i) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge reset_a) begin
    if (!reset_a) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  // Fires in the last waiting cycle so the FSM leaves exactly TIMEOUT_CYCLES after entry.
  assign expired_o = run_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule
`endif

// File: rtl/mult_seq_host.sv
// Host sequencer for a 4-step multiplier controller: accepts operands, pulses start,
// walks count 0..3, captures the product. MULT_HOST_ERR_CHECK_EN adds error/timeout results.
module mult_seq_host
  import mult_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        reset_a,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  output logic        start,
  output logic [1:0]  count,
  output logic [7:0]  op_a,
  output logic [7:0]  op_b,
  input  logic        done,
  input  logic [2:0]  state_out,
  input  logic [15:0] product,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_product,
  output logic        res_err
);

  // Both ports use valid/ready: a transfer happens on a rising edge where both are 1;
  // res_valid and its payload stay stable until that edge.

  host_state_t state_q;
  logic [1:0]  step_q, step_d;
  logic        start_q, res_valid_q, res_err_q;
  logic [15:0] res_product_q;
  logic [7:0]  op_a_q, op_b_q;
  logic        err_req;

`ifdef MULT_HOST_ERR_CHECK_EN
  logic timeout;

  mult_host_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk       (clk),
    .reset_a   (reset_a),
    .run_i     (state_q == H_WAIT),
    .expired_o (timeout)
  );

  // A done arriving in the timeout cycle still wins; a controller ERR always aborts.
  always_comb begin
    err_req = 1'b0;
    if (state_q == H_RUN || state_q == H_WAIT)
      err_req = (state_out == C_ERR) || (timeout && !done);
  end
`else
  logic cfg_unused;
  assign err_req    = 1'b0;
  assign cfg_unused = (^state_out) ^ (TIMEOUT_CYCLES == 0);
`endif

  always_comb begin
    step_d = 2'd0;
    if (state_q == H_RUN && !err_req && step_q != 2'd3) step_d = step_q + 2'd1;
  end

  always_ff @(posedge clk or negedge reset_a) begin
    if (!reset_a) step_q <= 2'd0;
    else          step_q <= step_d;
  end

  always_ff @(posedge clk or negedge reset_a) begin
    if (!reset_a) begin
      state_q       <= H_IDLE;
      start_q       <= 1'b0;
      op_a_q        <= 8'd0;
      op_b_q        <= 8'd0;
      res_valid_q   <= 1'b0;
      res_product_q <= 16'd0;
      res_err_q     <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        H_IDLE: begin
          if (in_valid) begin
            op_a_q  <= in_a;
            op_b_q  <= in_b;
            start_q <= 1'b1;
            state_q <= H_START;
          end
        end
        H_START: state_q <= H_RUN;
        H_RUN: begin
          if (err_req) begin
            res_valid_q   <= 1'b1;
            res_err_q     <= 1'b1;
            res_product_q <= 16'd0;
            state_q       <= H_RESP;
          end else if (step_q == 2'd3) begin
            state_q <= H_WAIT;
          end
        end
        H_WAIT: begin
          if (err_req) begin
            res_valid_q   <= 1'b1;
            res_err_q     <= 1'b1;
            res_product_q <= 16'd0;
            state_q       <= H_RESP;
          end else if (done) begin
            res_valid_q   <= 1'b1;
            res_err_q     <= 1'b0;
            res_product_q <= product;
            state_q       <= H_RESP;
          end
        end
        H_RESP: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= H_IDLE;
          end
        end
        default: state_q <= H_IDLE;
      endcase
    end
  end

  assign in_ready    = (state_q == H_IDLE);
  assign start       = start_q;
  assign count       = step_q;
  assign op_a        = op_a_q;
  assign op_b        = op_b_q;
  assign res_valid   = res_valid_q;
  assign res_product = res_product_q;
  assign res_err     = res_err_q;

endmodule

// File: tb/tb_mult_seq_host.sv
// Bench for mult_seq_host paired with a behavioural 2-bit-per-step multiplier controller;
// outputs are checked every cycle against a timeline model of each operation.
module tb_mult_seq_host;

  localparam int T   = 8;
  localparam int BIG = 32'h3fff_ffff;

  logic        clk = 1'b0;
  logic        reset_a = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_a = 8'd0, in_b = 8'd0;
  logic        start;
  logic [1:0]  count;
  logic [7:0]  op_a, op_b;
  logic        done;
  logic [2:0]  state_out;
  logic [15:0] product;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [15:0] res_product;
  logic        res_err;

  mult_seq_host #(.TIMEOUT_CYCLES(T)) dut (
    .clk         (clk),
    .reset_a     (reset_a),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .start       (start),
    .count       (count),
    .op_a        (op_a),
    .op_b        (op_b),
    .done        (done),
    .state_out   (state_out),
    .product     (product),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_product (res_product),
    .res_err     (res_err)
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- controller + datapath model ----------------
  logic force_err = 1'b0;
  logic done_off  = 1'b0;
  int   done_dly  = 0;
  int   c_st;
  int   c_wait;
  logic [15:0] c_acc;

  function automatic logic [15:0] step_acc(input logic [15:0] acc, input logic [7:0] a,
                                           input logic [7:0] b, input logic [1:0] k);
    int sl;
    sl = int'((b >> (2 * int'(k))) & 8'h03);
    return 16'(int'(acc) + int'(a) * sl * (1 << (2 * int'(k))));
  endfunction

  always @(posedge clk or negedge reset_a) begin
    if (!reset_a) begin
      c_st <= 0; c_acc <= 16'd0; c_wait <= 0;
    end else if (start) begin
      c_st <= 1; c_acc <= 16'd0;
    end else if (c_st >= 1 && c_st <= 3) begin
      c_acc <= step_acc(c_acc, op_a, op_b, count);
      c_st  <= (count == 2'd3) ? 4 : ((count == 2'd2) ? 3 : 2);
      if (count == 2'd3) c_wait <= done_dly;
    end else if (c_st == 4 && c_wait > 0) begin
      c_wait <= c_wait - 1;
    end
  end

  assign done      = (c_st == 4) && (c_wait == 0) && !done_off;
  assign state_out = force_err ? 3'd5 : 3'(c_st);
  assign product   = c_acc;

  // ---------------- scoreboard / timeline model ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [16:0] exp_q[$];

  int acc_e = 0, resp_e = 0, hs_e = 0;
  logic [7:0]  cur_a = 8'd0, cur_b = 8'd0;
  logic [15:0] cur_prod = 16'd0, prev_prod = 16'd0;
  logic        cur_err = 1'b0, prev_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    acc_e = 0; resp_e = 0; hs_e = 0;
    cur_a = 8'd0; cur_b = 8'd0;
    cur_prod = 16'd0; prev_prod = 16'd0;
    cur_err = 1'b0; prev_err = 1'b0;
    exp_q.delete();
    force_err = 1'b0; done_off = 1'b0;
  endtask

  // Per-cycle comparison: busy spans accept edge to handshake edge; the result
  // registers show this op's result from the response edge onward.
  initial begin
    logic e_busy;
    forever begin
      @(posedge clk); #3;
      e_busy = (cyc >= acc_e) && (cyc < hs_e);
      check("in_ready", in_ready, !e_busy);
      check("start", start, (cyc == acc_e) && e_busy);
      check("count", count,
            (cyc >= acc_e + 1 && cyc <= acc_e + 4 && cyc < resp_e && e_busy) ? cyc - acc_e - 1 : 0);
      check("op_a", op_a, cur_a);
      check("op_b", op_b, cur_b);
      check("res_valid", res_valid, (cyc >= resp_e) && (cyc < hs_e));
      check("res_product", res_product, (cyc >= resp_e) ? cur_prod : prev_prod);
      check("res_err", res_err, (cyc >= resp_e) ? cur_err : prev_err);
    end
  end

  // ---------------- driver ----------------
  // mode: 0 nominal, 1 controller ERR during run, 2 done never arrives, 3 reset at count=2
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int dly,
                        input int rdy_lo, input int mode, input bit pin_en,
                        input logic [15:0] pin_prod, input logic pin_err);
    int lo;
    logic [16:0] sb;
    lo        = rdy_lo;
    done_off  = (mode == 2);
    done_dly  = dly;
    force_err = 1'b0;
    prev_prod = cur_prod; prev_err = cur_err;
    cur_a = a; cur_b = b;
    in_a = a; in_b = b; in_valid = 1'b1;
    acc_e = cyc + 1; hs_e = BIG;
    cur_prod = 16'(a) * 16'(b); cur_err = 1'b0;
    resp_e = acc_e + 6 + dly;
`ifdef MULT_HOST_ERR_CHECK_EN
    if (mode == 1) begin cur_prod = 16'd0; cur_err = 1'b1; resp_e = acc_e + 3; end
    if (mode == 2) begin cur_prod = 16'd0; cur_err = 1'b1; resp_e = acc_e + 5 + T; end
`endif
    if (mode == 3) resp_e = BIG;
    if (mode != 3) exp_q.push_back({cur_err, cur_prod});
    for (int guard = 0; guard < 200; guard++) begin
      @(negedge clk);
      if (cyc == acc_e) in_valid = 1'b0;
      else              in_valid = 1'($urandom_range(0, 1));
      in_a = 8'($urandom); in_b = 8'($urandom);
      if (pin_en && cyc == acc_e) check("pin_start", start, 1);
      if (pin_en && cyc >= acc_e + 1 && cyc <= acc_e + 4 && cyc < resp_e)
        check("pin_count", count, cyc - acc_e - 1);
      if (pin_en && cyc == resp_e - 1) check("pin_valid_pre", res_valid, 0);
      if (pin_en && cyc == resp_e) check("pin_valid_rise", res_valid, 1);
      if (mode == 1 && cyc == acc_e + 2) force_err = 1'b1;
      if (mode == 3 && cyc == acc_e + 3) begin
        check("pin_count_at_rst", count, 2);
        reset_a = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("pin_rst_valid", res_valid, 0);
        reset_a = 1'b1;
        return;
      end
      if (cyc < resp_e) begin
        res_ready = 1'($urandom_range(0, 1));
      end else begin
        force_err = 1'b0;
        if (lo > 0) begin
          res_ready = 1'b0;
          lo--;
        end else begin
          res_ready = 1'b1;
          sb = exp_q.pop_front();
          check("sb_product", res_product, sb[15:0]);
          check("sb_err", res_err, sb[16]);
          if (pin_en) begin
            check("pin_product", res_product, pin_prod);
            check("pin_err", res_err, pin_err);
          end
          hs_e = cyc + 1;
          @(negedge clk);
          in_valid = 1'b0; res_ready = 1'b0;
          return;
        end
      end
    end
    check("op_timeout", 0, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int mode;
    #1 reset_a = 1'b0;
    repeat (3) @(negedge clk);
    reset_a = 1'b1;
    @(negedge clk);
    check("pin_ready_after_rst", in_ready, 1);
    check("pin_valid_after_rst", res_valid, 0);

    run_op(8'hFF, 8'hFF, 0, 0, 0, 1'b1, 16'hFE01, 1'b0);
    run_op(8'h12, 8'h34, 0, 3, 0, 1'b1, 16'h03A8, 1'b0);
`ifdef MULT_HOST_ERR_CHECK_EN
    run_op(8'h55, 8'h66, 0, 0, 1, 1'b1, 16'h0000, 1'b1);
    run_op(8'h0A, 8'h0B, 0, 0, 0, 1'b1, 16'h006E, 1'b0);
    run_op(8'h77, 8'h88, 0, 0, 2, 1'b1, 16'h0000, 1'b1);
    run_op(8'h0A, 8'h0B, 2, 1, 0, 1'b1, 16'h006E, 1'b0);
`else
    run_op(8'h55, 8'h66, 0, 0, 1, 1'b1, 16'h21DE, 1'b0);
    run_op(8'h0A, 8'h0B, 20, 0, 0, 1'b1, 16'h006E, 1'b0);
`endif
    run_op(8'hC3, 8'h5A, 0, 0, 3, 1'b1, 16'h0000, 1'b0);
    run_op(8'h03, 8'h05, 0, 0, 0, 1'b1, 16'h000F, 1'b0);

    for (int i = 0; i < 30; i++) begin
      mode = ($urandom_range(0, 4) == 0) ? 1 : 0;
      run_op(8'($urandom), 8'($urandom), $urandom_range(0, 3), $urandom_range(0, 2),
             mode, 1'b0, 16'h0000, 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mult_seq_host.md
MULT_SEQ_HOST -- requirements
Module: mult_seq_host

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 8, is the maximum number of cycles to wait for done after count=3 has been driven.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset_a  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  operand pair offered.
REQ-005 in_ready  output  1  host can accept an operand pair.
REQ-006 in_a, in_b  input  8 each  unsigned operands.
REQ-007 start  output  1  start pulse to the multiplier controller.
REQ-008 count  output  2  step index to the multiplier controller.
REQ-009 op_a, op_b  output  8 each  registered operands to the multiplier datapath.
REQ-010 done  input  1  controller completion flag.
REQ-011 state_out  input  3  controller state: 0 IDLE, 1 LSB, 2 MID, 3 MSB, 4 CALC_DONE, 5 ERR.
REQ-012 product  input  16  datapath accumulator.
REQ-013 res_valid  output  1  result available.
REQ-014 res_ready  input  1  result consumer ready.
REQ-015 res_product  output  16  captured product.
REQ-016 res_err  output  1  result is an error, not a product.

Function
REQ-017 The FSM SHALL have states H_IDLE, H_START, H_RUN, H_WAIT and H_RESP.
REQ-018 in_ready SHALL be 1 only in H_IDLE; accepting (in_valid&in_ready) latches in_a/in_b into op_a/op_b and goes to H_START.
REQ-019 In H_START, start SHALL be 1 for exactly one cycle with count=0, then H_RUN.
REQ-020 In H_RUN, count SHALL drive 0,1,2,3 on consecutive cycles with start=0, then H_WAIT.
REQ-021 In H_WAIT, with start=0 and count=0, done=1 SHALL capture product into res_product, clear res_err, and go to H_RESP.
REQ-022 op_a/op_b SHALL stay constant from the accept edge until leaving H_RESP.
REQ-023 Nominal latency: res_valid SHALL rise 6 clock edges after the accept edge.
REQ-024 In H_RESP, res_valid=1; res_product/res_err SHALL hold until res_valid&res_ready, then go to H_IDLE.
REQ-025 Back-to-back: the next accept SHALL occur no earlier than the cycle after the result handshake.
REQ-026 The sequence from controller ERR SHALL be identical to that from IDLE, because start=1 moves ERR to LSB.

Reset
REQ-027 While reset_a=0, the FSM SHALL be in H_IDLE with start=0, count=0, op_a=op_b=0, res_valid=0, res_product=0, res_err=0 and the timeout counter at 0.
REQ-028 Reset asserted mid-operation SHALL abort immediately with no result emitted.
REQ-029 After release, in_ready SHALL be 1.

Configuration
REQ-030 With MULT_HOST_ERR_CHECK_EN defined, from H_START+1 through H_WAIT, state_out=5, or TIMEOUT_CYCLES cycles in H_WAIT without done, SHALL enter H_RESP with res_err=1 and res_product=0.
REQ-031 Without MULT_HOST_ERR_CHECK_EN, res_err SHALL be constant 0, state_out SHALL be ignored, and H_WAIT SHALL wait indefinitely for done.

Structure
REQ-032 Shared package mult_pkg SHALL hold the controller state encodings (IDLE..ERR, 3-bit), the host state type and the default TIMEOUT_CYCLES.
REQ-033 The timeout counter SHALL be sub-module mult_host_timer, present only when MULT_HOST_ERR_CHECK_EN is defined.
REQ-034 The step counter SHALL reside in the top module.

Verification (bench pairs the host with the multiplier controller and datapath)
REQ-035 0xFF x 0xFF, res_ready=1 -> start high for 1 cycle; count 0,1,2,3; res_product=0xFE01 and res_valid 6 edges after accept; res_err=0.
REQ-036 0x12 x 0x34, res_ready held low 3 cycles -> res_product=0x03A8 held stable, in_ready=0 until the handshake.
REQ-037 Force state_out=5 during H_RUN (with _EN) -> res_err=1, res_product=0; then 0x0A x 0x0B -> 0x006E, res_err=0.
REQ-038 done tied 0 (with _EN) -> res_err=1 exactly TIMEOUT_CYCLES cycles after entering H_WAIT.
REQ-039 reset_a pulsed low during H_RUN count=2 -> all outputs at reset values, no res_valid; the next operation 0x03 x 0x05 -> 0x000F.
REQ-040 Without _EN, done delayed 20 cycles -> still waiting, then correct product, res_err=0.
